fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_pkg.sv | 22 ++
 rtl/fb_wait_counter.sv | 35 +++
 rtl/fb_arbiter.sv | 162 ++++++++++++++++
 tb/tb_fb_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer arbiter.
// Holds the default address/pixel widths, the CPU starvation limit,
// the arbiter state encoding and a counter-width helper.
package fb_pkg;

  localparam int FB_ADR_W    = 10;
  localparam int FB_DATA_W   = 8;
  localparam int FB_MAX_WAIT = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GNT_VGA    = 2'd1,
    GNT_CPU_WR = 2'd2,
    GNT_CPU_RD = 2'd3
  } fb_state_t;

  // Bits needed to count 0..max; never narrower than one bit.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/fb_wait_counter.sv
// Saturating wait counter used to bound how long the CPU can be starved.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   inc         - count one lost arbitration (ignored once saturated)
//   clr         - return to zero (wins over inc)
//   sat         - counter has reached MAX
module fb_wait_counter
  import fb_pkg::*;
#(
  parameter int MAX = FB_MAX_WAIT
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = cnt_w(MAX);

  logic [CW-1:0] count;

  assign sat = (count == CW'(MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer arbiter: shares one synchronous single-port RAM between a
// VGA pixel fetcher (pulsed requests, one-deep pending slot) and a CPU
// (level request/ack handshake). VGA has priority; the CPU is forced in
// once it has lost MAX_WAIT consecutive competing edges.
// Ports:
//   clk, reset                        - system clock, async active-high reset
//   vga_req, vga_adr                  - VGA pixel request pulse and address
//   vga_pixel, vga_valid, vga_ovf     - returned pixel, valid pulse, sticky lost-request flag
//   cpu_req, cpu_we, cpu_adr, cpu_wdata - CPU request held until cpu_ack
//   cpu_ack, cpu_rdata                - CPU completion pulse and read data
//   mem_adr, mem_we, mem_wdata        - registered RAM command
//   mem_rdata                         - RAM read data (one cycle after address)
//
// state      | meaning
// -----------+------------------------------------------------
// IDLE       | nothing granted this cycle
// GNT_VGA    | RAM command in flight is a VGA pixel read
// GNT_CPU_WR | RAM command in flight is a CPU write
// GNT_CPU_RD | RAM command in flight is a CPU read
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADR_W    = FB_ADR_W,
  parameter int DATA_W   = FB_DATA_W,
  parameter int MAX_WAIT = FB_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADR_W-1:0]  vga_adr,
  output logic [DATA_W-1:0] vga_pixel,
  output logic              vga_valid,
  output logic              vga_ovf,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADR_W-1:0]  cpu_adr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADR_W-1:0]  mem_adr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  fb_state_t state, state_nxt;

  logic             vga_comp, cpu_comp;
  logic             vga_win, cpu_win;
  logic             wait_inc, wait_clr, wait_sat;
  logic             pend_valid;
  logic [ADR_W-1:0] pend_adr;
  logic [ADR_W-1:0] vga_sel_adr;
  logic             cpu_busy;
  logic             vga_rd_d1, cpu_rd_d1;

  // The pending slot is older than any new pulse, so it is served first.
  assign vga_comp    = vga_req | pend_valid;
  assign vga_sel_adr = pend_valid ? pend_adr : vga_adr;

  // cpu_busy stays set through the ack cycle so a still-held cpu_req
  // is not mistaken for a fresh request.
  assign cpu_comp = cpu_req & ~cpu_busy;

  assign wait_inc = cpu_comp & vga_win;
  assign wait_clr = cpu_win;

  fb_wait_counter #(
    .MAX (MAX_WAIT)
  ) u_wait (
    .clk   (clk),
    .reset (reset),
    .inc   (wait_inc),
    .clr   (wait_clr),
    .sat   (wait_sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    cpu_win   = 1'b0;
    vga_win   = 1'b0;
    if (cpu_comp && (!vga_comp || wait_sat)) begin
      cpu_win   = 1'b1;
      state_nxt = cpu_we ? GNT_CPU_WR : GNT_CPU_RD;
    end else if (vga_comp) begin
      vga_win   = 1'b1;
      state_nxt = GNT_VGA;
    end
  end

  // Grant at edge E: command registered at E, RAM samples it at E+1,
  // read data captured at E+2. A CPU write completes once the RAM has
  // taken it at E+1. Same-address VGA-before-CPU-write ordering falls
  // out of the single port: the write is only issued on a later edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_adr   <= '0;
      vga_ovf    <= 1'b0;
      cpu_busy   <= 1'b0;
      mem_adr    <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      vga_rd_d1  <= 1'b0;
      cpu_rd_d1  <= 1'b0;
      vga_pixel  <= '0;
      vga_valid  <= 1'b0;
      cpu_rdata  <= '0;
      cpu_ack    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (cpu_win) begin
        mem_adr   <= cpu_adr;
        mem_we    <= cpu_we;
        mem_wdata <= cpu_wdata;
      end else if (vga_win) begin
        mem_adr <= vga_sel_adr;
      end

      if (vga_win) begin
        // Slot drained (or bypassed); a new pulse behind a pending entry refills it.
        pend_valid <= pend_valid & vga_req;
        if (pend_valid && vga_req) begin
          pend_adr <= vga_adr;
        end
      end else if (vga_req) begin
        if (pend_valid) begin
          vga_ovf <= 1'b1;
        end else begin
          pend_valid <= 1'b1;
          pend_adr   <= vga_adr;
        end
      end

      if (cpu_win) begin
        cpu_busy <= 1'b1;
      end else if (cpu_ack) begin
        cpu_busy <= 1'b0;
      end

      vga_rd_d1 <= (state == GNT_VGA);
      cpu_rd_d1 <= (state == GNT_CPU_RD);
      vga_valid <= vga_rd_d1;
      cpu_ack   <= (state == GNT_CPU_WR) | cpu_rd_d1;
      if (vga_rd_d1) begin
        vga_pixel <= mem_rdata;
      end
      if (cpu_rd_d1) begin
        cpu_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural synchronous RAM.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_fb_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       vga_req;
  logic [9:0] vga_adr;
  logic [7:0] vga_pixel;
  logic       vga_valid;
  logic       vga_ovf;
  logic       cpu_req;
  logic       cpu_we;
  logic [9:0] cpu_adr;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic [9:0] mem_adr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] mem [0:1023];

  int checks = 0;
  int errors = 0;
  int acks;

  fb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .vga_req   (vga_req),
    .vga_adr   (vga_adr),
    .vga_pixel (vga_pixel),
    .vga_valid (vga_valid),
    .vga_ovf   (vga_ovf),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_adr   (cpu_adr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .mem_adr   (mem_adr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_adr] <= mem_wdata;
    mem_rdata <= mem[mem_adr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset     = 1'b1;
    vga_req   = 1'b0;
    vga_adr   = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_adr   = '0;
    cpu_wdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h005] = 8'h3C;
    mem[10'h020] = 8'hAA;

    // reset state
    step(2);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_adr", 32'(mem_adr), 32'h0);
    check("rst_cpu_ack", 32'(cpu_ack), 32'h0);
    check("rst_vga_valid", 32'(vga_valid), 32'h0);
    check("rst_vga_ovf", 32'(vga_ovf), 32'h0);
    check("rst_vga_pixel", 32'(vga_pixel), 32'h0);
    reset = 1'b0;
    step(1);

    // VGA only
    vga_req = 1'b1;
    vga_adr = 10'h005;
    step(1);
    vga_req = 1'b0;
    check("vga_mem_adr", 32'(mem_adr), 32'h005);
    check("vga_mem_we", 32'(mem_we), 32'h0);
    step(1);
    check("vga_valid_e1", 32'(vga_valid), 32'h0);
    step(1);
    check("vga_valid_e2", 32'(vga_valid), 32'h1);
    check("vga_pixel", 32'(vga_pixel), 32'h3C);
    step(1);
    check("vga_valid_e3", 32'(vga_valid), 32'h0);

    // CPU write then read back
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_adr   = 10'h010;
    cpu_wdata = 8'h7E;
    step(1);
    check("wr_mem_we", 32'(mem_we), 32'h1);
    check("wr_mem_adr", 32'(mem_adr), 32'h010);
    check("wr_mem_wdata", 32'(mem_wdata), 32'h7E);
    check("wr_ack_e0", 32'(cpu_ack), 32'h0);
    step(1);
    check("wr_ack_e1", 32'(cpu_ack), 32'h1);
    check("wr_mem_we_e1", 32'(mem_we), 32'h0);
    check("wr_ram", 32'(mem[10'h010]), 32'h7E);
    cpu_req = 1'b0;
    step(1);
    check("wr_ack_e2", 32'(cpu_ack), 32'h0);
    cpu_req = 1'b1;
    cpu_we  = 1'b0;
    step(1);
    check("rd_mem_we", 32'(mem_we), 32'h0);
    check("rd_ack_e0", 32'(cpu_ack), 32'h0);
    step(1);
    check("rd_ack_e1", 32'(cpu_ack), 32'h0);
    step(1);
    check("rd_ack_e2", 32'(cpu_ack), 32'h1);
    check("rd_data", 32'(cpu_rdata), 32'h7E);
    cpu_req = 1'b0;
    step(1);
    check("rd_ack_e3", 32'(cpu_ack), 32'h0);
    step(1);

    // same-edge VGA read and CPU write to one address
    vga_req   = 1'b1;
    vga_adr   = 10'h020;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_adr   = 10'h020;
    cpu_wdata = 8'h55;
    step(1);
    vga_req = 1'b0;
    check("col_vga_first_we", 32'(mem_we), 32'h0);
    check("col_vga_first_adr", 32'(mem_adr), 32'h020);
    step(1);
    check("col_cpu_we", 32'(mem_we), 32'h1);
    check("col_cpu_wdata", 32'(mem_wdata), 32'h55);
    step(1);
    check("col_vga_valid", 32'(vga_valid), 32'h1);
    check("col_vga_pixel", 32'(vga_pixel), 32'hAA);
    check("col_cpu_ack", 32'(cpu_ack), 32'h1);
    check("col_ram", 32'(mem[10'h020]), 32'h55);
    cpu_req = 1'b0;
    step(3);

    // CPU held against a VGA pulse every edge
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_adr   = 10'h030;
    cpu_wdata = 8'h11;
    vga_req   = 1'b1;
    for (int k = 0; k < 12; k++) begin
      vga_adr = 10'h100 + 10'(k);
      step(1);
      if (k == 3) check("starve_e4_we", 32'(mem_we), 32'h0);
      if (k == 4) begin
        check("force_e5_we", 32'(mem_we), 32'h1);
        check("force_e5_adr", 32'(mem_adr), 32'h030);
        check("force_e5_ovf", 32'(vga_ovf), 32'h0);
      end
      if (k == 5) begin
        check("pend_e6_ack", 32'(cpu_ack), 32'h1);
        check("pend_e6_adr", 32'(mem_adr), 32'h104);
        check("pend_e6_ovf", 32'(vga_ovf), 32'h0);
      end
      if (k == 10) begin
        check("starve2_e11_we", 32'(mem_we), 32'h0);
        check("starve2_e11_ovf", 32'(vga_ovf), 32'h0);
      end
      if (k == 11) begin
        check("force2_e12_we", 32'(mem_we), 32'h1);
        check("ovf_set", 32'(vga_ovf), 32'h1);
      end
    end
    vga_req = 1'b0;
    step(1);
    check("force2_ack", 32'(cpu_ack), 32'h1);
    cpu_req = 1'b0;
    step(3);
    check("ovf_sticky", 32'(vga_ovf), 32'h1);

    // reset in the middle of a CPU read
    cpu_req = 1'b1;
    cpu_we  = 1'b0;
    cpu_adr = 10'h010;
    step(2);
    reset = 1'b1;
    #1;
    check("mid_rst_mem_adr", 32'(mem_adr), 32'h0);
    check("mid_rst_mem_we", 32'(mem_we), 32'h0);
    check("mid_rst_cpu_ack", 32'(cpu_ack), 32'h0);
    check("mid_rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
    check("mid_rst_vga_ovf", 32'(vga_ovf), 32'h0);
    check("mid_rst_vga_valid", 32'(vga_valid), 32'h0);
    check("mid_rst_vga_pixel", 32'(vga_pixel), 32'h0);
    cpu_req = 1'b0;
    step(1);
    #2;
    reset = 1'b0;
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      if (cpu_ack) acks++;
    end
    check("post_rst_no_ack", 32'(acks), 32'h0);
    check("post_rst_mem_we", 32'(mem_we), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
